usb_out_ep_rx: RTL and testbench



---
 rtl/usb_ep_pkg.sv | 22 ++
 rtl/usb_ep_fifo.sv | 53 +++++
 rtl/usb_out_ep_rx.sv | 175 +++++++++++++++++
 tb/tb_usb_out_ep_rx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the USB OUT-endpoint receive path.
package usb_ep_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ENDPT_W = 4;
   localparam int unsigned LEN_W   = 11;

   localparam logic [LEN_W-1:0] LEN_MAX = 11'd2047;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DROP  = 2'd2,
      FLUSH = 2'd3
   } ep_state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/usb_ep_fifo.sv
// Synchronous FIFO of {last, data} entries; pointers carry one extra MSB
// so that full and empty can be told apart when the indices match.
module usb_ep_fifo
   import usb_ep_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  fifo_entry_t i_wr,
   input  logic        i_pop,
   output fifo_entry_t o_rd,
   output logic        o_full,
   output logic        o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   fifo_entry_t r_mem [DEPTH];
   logic [AW:0] r_wp;
   logic [AW:0] r_rp;
   logic        w_pop;

   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_rd    = r_mem[r_rp[AW-1:0]];

   // Pointer update; wrap-around is plain overflow of the extended pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (i_push) begin
            r_wp <= r_wp + PTR_ONE;
         end
         if (w_pop) begin
            r_rp <= r_rp + PTR_ONE;
         end
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wp[AW-1:0]] <= i_wr;
      end
   end

endmodule

// File: rtl/usb_out_ep_rx.sv
// OUT-endpoint receive path: USB core rx handshake -> stage byte -> FIFO -> stream.
// Define USB_RX_PKT_LEN_EN to add the pkt_len / pkt_len_vld packet length report.
module usb_out_ep_rx
   import usb_ep_pkg::*;
#(
   parameter int unsigned        DEPTH = 64,
   parameter logic [ENDPT_W-1:0] ENDPT = 4'd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ENDPT_W-1:0] endpt,
   input  logic               rxact,
   input  logic               rxval,
   input  logic [DATA_W-1:0]  rxdat,
   output logic               rxrdy,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic               zlp
`ifdef USB_RX_PKT_LEN_EN
   ,
   output logic [LEN_W-1:0]   pkt_len,
   output logic               pkt_len_vld
`endif
);

   ep_state_t          r_state;
   logic               r_stage_vld;
   logic [DATA_W-1:0]  r_stage_data;
   logic               r_zlp;

   logic               w_acc;
   logic               w_push;
   logic               w_end_push;
   logic               w_zlp_evt;
   logic               w_full;
   logic               w_empty;
   fifo_entry_t        w_wr_entry;
   fifo_entry_t        w_rd_entry;

   usb_ep_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wr    (w_wr_entry),
      .i_pop   (out_ready),
      .o_rd    (w_rd_entry),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? 8'd0 : w_rd_entry.data;
   assign out_last  = w_empty ? 1'b0 : w_rd_entry.last;
   assign zlp       = r_zlp;

   // Ready depends only on registered state, never on rxval.
   always_comb begin
      case (r_state)
         RECV:    rxrdy = !r_stage_vld || !w_full;
         DROP:    rxrdy = 1'b1;
         default: rxrdy = 1'b0;
      endcase
   end

   assign w_acc     = (r_state == RECV) && rxact && rxval && rxrdy;
   assign w_zlp_evt = (r_state == RECV) && !rxact && !r_stage_vld;

   // FIFO write: a new byte evicts the held one; packet end pushes it as last.
   always_comb begin
      w_push          = 1'b0;
      w_end_push      = 1'b0;
      w_wr_entry.last = 1'b0;
      w_wr_entry.data = r_stage_data;
      case (r_state)
         RECV: begin
            if (rxact) begin
               w_push = w_acc && r_stage_vld;
            end else if (r_stage_vld && !w_full) begin
               w_push          = 1'b1;
               w_end_push      = 1'b1;
               w_wr_entry.last = 1'b1;
            end else begin
               w_push = 1'b0;
            end
         end
         FLUSH: begin
            if (!w_full) begin
               w_push          = 1'b1;
               w_end_push      = 1'b1;
               w_wr_entry.last = 1'b1;
            end else begin
               w_push = 1'b0;
            end
         end
         default: w_push = 1'b0;
      endcase
   end

   // Endpoint FSM with stage register and zero-length-packet pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_stage_vld  <= 1'b0;
         r_stage_data <= 8'd0;
         r_zlp        <= 1'b0;
      end else begin
         r_zlp <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rxact) begin
                  r_state <= (endpt == ENDPT) ? RECV : DROP;
               end
            end
            RECV: begin
               if (w_acc) begin
                  r_stage_data <= rxdat;
                  r_stage_vld  <= 1'b1;
               end else if (w_zlp_evt) begin
                  r_zlp   <= 1'b1;
                  r_state <= IDLE;
               end else if (w_end_push) begin
                  r_stage_vld <= 1'b0;
                  r_state     <= IDLE;
               end else if (!rxact) begin
                  r_state <= FLUSH;
               end
            end
            DROP: begin
               if (!rxact) begin
                  r_state <= IDLE;
               end
            end
            FLUSH: begin
               if (w_end_push) begin
                  r_stage_vld <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef USB_RX_PKT_LEN_EN
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_pkt_len;
   logic             r_pkt_len_vld;

   assign pkt_len     = r_pkt_len;
   assign pkt_len_vld = r_pkt_len_vld;

   // Saturating byte count of the current packet, reported at packet end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= 11'd0;
         r_pkt_len     <= 11'd0;
         r_pkt_len_vld <= 1'b0;
      end else begin
         r_pkt_len_vld <= 1'b0;
         if (r_state == IDLE) begin
            r_cnt <= 11'd0;
         end else if (w_acc && (r_cnt != LEN_MAX)) begin
            r_cnt <= r_cnt + 11'd1;
         end
         if (w_end_push || w_zlp_evt) begin
            r_pkt_len_vld <= 1'b1;
            r_pkt_len     <= r_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_usb_out_ep_rx.sv
// Self-checking bench for usb_out_ep_rx: directed scenarios plus random packets
// checked every cycle against a queue-based packet model.
`timescale 1ns/1ps
module tb_usb_out_ep_rx;

   localparam int         DEPTH = 4;
   localparam logic [3:0] EP    = 4'd1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] endpt = 4'd0;
   logic       rxact = 1'b0;
   logic       rxval = 1'b0;
   logic [7:0] rxdat = 8'd0;
   logic       out_ready = 1'b0;
   logic       rxrdy, out_valid, out_last, zlp;
   logic [7:0] out_data;
`ifdef USB_RX_PKT_LEN_EN
   logic [10:0] pkt_len;
   logic        pkt_len_vld;
`endif

   int checks = 0;
   int errors = 0;

   usb_out_ep_rx #(.DEPTH(DEPTH), .ENDPT(EP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .endpt     (endpt),
      .rxact     (rxact),
      .rxval     (rxval),
      .rxdat     (rxdat),
      .rxrdy     (rxrdy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .zlp       (zlp)
`ifdef USB_RX_PKT_LEN_EN
      ,
      .pkt_len     (pkt_len),
      .pkt_len_vld (pkt_len_vld)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packet model: mode 0 idle, 1 collecting, 2 discarding, 3 waiting for room.
   int         m_mode = 0;
   logic [8:0] m_fifo[$];
   logic       m_held_vld = 1'b0;
   logic [7:0] m_held = 8'd0;
   int         m_cnt = 0;
   logic       e_zlp = 1'b0;
   bit         exp_rdy;
   int         occ;
`ifdef USB_RX_PKT_LEN_EN
   logic       e_len_vld = 1'b0;
   int         e_len = 0;
   int         len_q[$];
`endif

   logic [8:0] got_q[$];
   int         zlp_cnt = 0;
   int         valid_cycles = 0;

   task automatic model_finish();
      m_fifo.push_back({1'b1, m_held});
      m_held_vld = 1'b0;
      m_mode     = 0;
`ifdef USB_RX_PKT_LEN_EN
      e_len_vld = 1'b1;
      e_len     = m_cnt;
`endif
   endtask

   // Single compare process: check outputs against the model, then advance it.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_fifo.delete();
         m_mode = 0; m_held_vld = 1'b0; m_cnt = 0; e_zlp = 1'b0;
`ifdef USB_RX_PKT_LEN_EN
         e_len_vld = 1'b0;
         chk("rst_pkt_len_vld", 32'(pkt_len_vld), 32'd0);
`endif
         chk("rst_rxrdy", 32'(rxrdy), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_zlp", 32'(zlp), 32'd0);
      end else begin
         occ = m_fifo.size();
         exp_rdy = (m_mode == 1) ? (!m_held_vld || occ < DEPTH) : (m_mode == 2);
         chk("rxrdy", 32'(rxrdy), 32'(exp_rdy));
         chk("out_valid", 32'(out_valid), 32'(occ != 0));
         if (occ != 0) begin
            chk("out_data", 32'(out_data), 32'(m_fifo[0][7:0]));
            chk("out_last", 32'(out_last), 32'(m_fifo[0][8]));
         end
         chk("zlp", 32'(zlp), 32'(e_zlp));
`ifdef USB_RX_PKT_LEN_EN
         chk("pkt_len_vld", 32'(pkt_len_vld), 32'(e_len_vld));
         if (e_len_vld) chk("pkt_len", 32'(pkt_len), 32'(e_len));
         if (pkt_len_vld) len_q.push_back(int'(pkt_len));
         e_len_vld = 1'b0;
`endif
         if (out_valid && out_ready) got_q.push_back({out_last, out_data});
         if (out_valid) valid_cycles++;
         if (zlp) zlp_cnt++;

         e_zlp = 1'b0;
         if (occ != 0 && out_ready) void'(m_fifo.pop_front());
         case (m_mode)
            0: if (rxact) begin
                  m_mode = (endpt == EP) ? 1 : 2;
                  m_cnt  = 0;
               end
            1: if (rxact) begin
                  if (rxval && exp_rdy) begin
                     if (m_held_vld) m_fifo.push_back({1'b0, m_held});
                     m_held = rxdat; m_held_vld = 1'b1;
                     if (m_cnt < 2047) m_cnt++;
                  end
               end else if (!m_held_vld) begin
                  e_zlp = 1'b1; m_mode = 0;
`ifdef USB_RX_PKT_LEN_EN
                  e_len_vld = 1'b1; e_len = 0;
`endif
               end else if (occ < DEPTH) begin
                  model_finish();
               end else begin
                  m_mode = 3;
               end
            2: if (!rxact) m_mode = 0;
            default: if (occ < DEPTH) model_finish();
         endcase
      end
   end

   logic [7:0] pkt_q[$];
   int stall_cnt = 0;
   int first_stall_at = -1;
   bit scramble_ep = 1'b0;
   bit rand_done = 1'b0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input logic [3:0] ep, input int gap_pct);
      int acc_n;
      int waited;
      bit done;
      acc_n = 0;
      endpt = ep; rxact = 1'b1;
      tick();
      foreach (pkt_q[i]) begin
         waited = 0; done = 1'b0;
         while (!done) begin
            rxval = ($urandom_range(99) >= gap_pct);
            rxdat = pkt_q[i];
            @(negedge clk);
            done = rxval && rxrdy;
            if (rxval && !rxrdy) begin
               stall_cnt++;
               if (first_stall_at < 0) first_stall_at = acc_n;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 500) begin
               chk("byte_accept_timeout", 32'(waited), 32'd0);
               done = 1'b1;
            end
         end
         acc_n++;
         if (scramble_ep) endpt = 4'($urandom);
      end
      rxval = 1'b0; rxact = 1'b0;
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rxrdy", 32'(rxrdy), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      tick(); rst_n = 1'b1;
      tick();

      // T1: basic packet to our endpoint.
      out_ready = 1'b1; got_q.delete(); zlp_cnt = 0;
      pkt_q = '{8'h11, 8'h22, 8'h33};
      send_pkt(EP, 0);
      repeat (5) tick();
      chk("t1_count", 32'(got_q.size()), 32'd3);
      chk("t1_b0", 32'(got_q[0]), 32'h011);
      chk("t1_b1", 32'(got_q[1]), 32'h022);
      chk("t1_b2", 32'(got_q[2]), 32'h133);
      chk("t1_zlp", 32'(zlp_cnt), 32'd0);

      // T2: foreign endpoint is sunk.
      valid_cycles = 0; stall_cnt = 0;
      pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_pkt(4'd2, 0);
      repeat (3) tick();
      chk("t2_stalls", 32'(stall_cnt), 32'd0);
      chk("t2_valid_cycles", 32'(valid_cycles), 32'd0);

      // T3: back-pressure with an 8-byte packet.
      out_ready = 1'b0; got_q.delete(); first_stall_at = -1;
      pkt_q.delete();
      for (int i = 1; i <= 8; i++) pkt_q.push_back(8'(8'hA0 + i));
      fork
         send_pkt(EP, 0);
         begin
            int n;
            n = 0;
            while (first_stall_at < 0 && n < 200) begin tick(); n++; end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            @(negedge clk);
            chk("t3_rxrdy_after_pop", 32'(rxrdy), 32'd1);
            @(posedge clk); #1; out_ready = 1'b1;
         end
      join
      repeat (8) tick();
      chk("t3_first_stall", 32'(first_stall_at), 32'd5);
      chk("t3_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk("t3_byte", 32'(got_q[i]), 32'({(i == 7), 8'(8'hA1 + i)}));

      // T4: FIFO full when rxact falls -> flush after one pop.
      out_ready = 1'b0; got_q.delete();
      pkt_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      send_pkt(EP, 0);
      tick();
      chk("t4_flush_rxrdy", 32'(rxrdy), 32'd0);
      chk("t4_flush_valid", 32'(out_valid), 32'd1);
      chk("t4_flush_head", 32'({out_last, out_data}), 32'h0C1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (8) tick();
      chk("t4_count", 32'(got_q.size()), 32'd5);
      chk("t4_b3", 32'(got_q[3]), 32'h0C4);
      chk("t4_b4", 32'(got_q[4]), 32'h1C5);

      // T5: zero-length packet, then lengths 3 and saturated.
      zlp_cnt = 0;
`ifdef USB_RX_PKT_LEN_EN
      len_q.delete();
`endif
      endpt = EP; rxact = 1'b1; tick(); tick();
      rxact = 1'b0; repeat (3) tick();
      chk("t5_zlp_count", 32'(zlp_cnt), 32'd1);
      pkt_q = '{8'h5A, 8'h5B, 8'h5C};
      send_pkt(EP, 0);
      repeat (3) tick();
      pkt_q.delete();
      for (int i = 0; i < 2050; i++) pkt_q.push_back(8'(i));
      send_pkt(EP, 0);
      repeat (8) tick();
      chk("t5_zlp_total", 32'(zlp_cnt), 32'd1);
`ifdef USB_RX_PKT_LEN_EN
      chk("t5_len_events", 32'(len_q.size()), 32'd3);
      chk("t5_len_zlp", 32'(len_q[0]), 32'd0);
      chk("t5_len_3", 32'(len_q[1]), 32'd3);
      chk("t5_len_sat", 32'(len_q[2]), 32'd2047);
`endif

      // T6: reset in the middle of a packet.
      out_ready = 1'b0;
      endpt = EP; rxact = 1'b1; tick();
      rxval = 1'b1; rxdat = 8'h55; tick();
      rxdat = 8'h66; tick();
      rxval = 1'b0; tick();
      chk("t6_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0; #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_rxrdy", 32'(rxrdy), 32'd0);
      rxact = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1; tick();
      out_ready = 1'b1; got_q.delete();
      pkt_q = '{8'h77, 8'h88};
      send_pkt(EP, 0);
      repeat (5) tick();
      chk("t6_count", 32'(got_q.size()), 32'd2);
      chk("t6_b0", 32'(got_q[0]), 32'h077);
      chk("t6_b1", 32'(got_q[1]), 32'h188);

      // Random packets with random gaps, endpoints and back-pressure.
      scramble_ep = 1'b1;
      fork
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(3) != 0);
               tick();
            end
         end
      join_none
      for (int p = 0; p < 40; p++) begin
         pkt_q.delete();
         for (int i = 0; i < int'($urandom_range(12)); i++) pkt_q.push_back(8'($urandom));
         send_pkt(($urandom_range(3) == 0) ? 4'($urandom_range(15)) : EP, 30);
         repeat ($urandom_range(2)) tick();
      end
      rand_done = 1'b1;
      tick();
      out_ready = 1'b1;
      repeat (30) tick();
      chk("final_drained", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
